rf_writeback_ctrl: RTL

Write-side controller for the KGP-RISC register file. It merges single-cycle ALU results and multi-cycle load returns into the register file's single write port (regWrite/writeAddr/writeData). Load returns are buffered in a small FIFO. The block publishes a per-register busy mask so the issue stage can stall on pending writes.

---
 rtl/kgp_risc_pkg.sv | 31 +++
 rtl/wb_fifo.sv | 89 ++++++++
 rtl/rf_writeback_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/kgp_risc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kgp_risc_pkg
// Purpose  : Shared definitions for the KGP-RISC register-file write side:
//            register geometry, the writeback request record and the one-hot
//            address decoder used to build the per-register busy mask.
// Contents : REG_ADDR_W, REG_DATA_W, NUM_REGS, wb_req_t, addr_onehot()
// Revision : 1.0 - initial release
// ============================================================================
package kgp_risc_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // One pending register-file write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  // Decode a register address into a one-hot register vector.
  function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage : kgp_risc_pkg
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Synchronous FIFO for load returns. Besides the usual push/pop
//            and full/empty/count it exposes, per storage slot, a valid bit
//            and the top TAG_W bits of the stored word so the parent can see
//            every queued destination register at once.
// Ports    : clk, rst        - clock, async active-high reset
//            push_i, pop_i   - enqueue / dequeue requests (ignored when
//                              full / empty respectively)
//            wdata_i         - word to enqueue
//            rdata_o         - word at the head
//            full_o, empty_o - occupancy flags
//            count_o         - number of occupied slots
//            tags_o          - flattened TAG_W-bit tag of every slot
//            valid_o         - slot i holds a queued entry
// Revision : 1.0 - initial release
// ============================================================================
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int TAG_W = 5,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [CNT_W-1:0]       count_o,
  output logic [DEPTH*TAG_W-1:0] tags_o,
  output logic [DEPTH-1:0]       valid_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic push_ok;
  logic pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Push is gated by full alone: a same-cycle pop never frees room early.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the valid vector masks stale slots.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Slot i is occupied when its distance from the read pointer (modulo
  // DEPTH, which is a power of two) is below the occupancy count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] offset;
      assign offset                     = PTR_W'(gi) - rd_ptr_q;
      assign valid_o[gi]                = (CNT_W'(offset) < count_q);
      assign tags_o[gi*TAG_W +: TAG_W]  = mem_q[gi][WIDTH-1 -: TAG_W];
    end
  endgenerate

endmodule : wb_fifo
`default_nettype wire

// File: rtl/rf_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_writeback_ctrl
// Purpose  : Write-side controller for the KGP-RISC register file. Merges
//            single-cycle ALU results and buffered load returns into the one
//            register-file write port, tracks pending writes per register and
//            throttles the ALU when load returns starve.
// Ports    : clk, rst                     - clock, async active-high reset
//            alu_valid/alu_addr/alu_data  - ALU result (no backpressure)
//            ld_valid/ld_ready            - load-return handshake
//            ld_addr/ld_data              - load-return payload
//            regWrite/writeAddr/writeData - registered register-file write
//            busy_mask                    - registers with a pending write
//            alu_stall                    - ask upstream to skip ALU next cycle
//            fifo_count                   - queued load returns
//            wb_hazard                    - sticky ordering-violation flag
// Revision : 1.0 - initial release
// ============================================================================
module rf_writeback_ctrl
  import kgp_risc_pkg::*;
#(
  parameter int DATA_W       = REG_DATA_W,
  parameter int ADDR_W       = REG_ADDR_W,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_addr,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic [DATA_W-1:0]          ld_data,
  output logic                       regWrite,
  output logic [ADDR_W-1:0]          writeAddr,
  output logic [DATA_W-1:0]          writeData,
  output logic [2**ADDR_W-1:0]       busy_mask,
  output logic                       alu_stall,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       wb_hazard
);

  localparam int NREG  = 2 ** ADDR_W;
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  // --------------------------------------------------------------------------
  // Load-return FIFO; entries are {addr, data} with the address on top.
  // --------------------------------------------------------------------------
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ENT_W-1:0]        fifo_head;
  logic [CNT_W-1:0]        fifo_cnt;
  logic [DEPTH*ADDR_W-1:0] fifo_tags;
  logic [DEPTH-1:0]        fifo_valid;

  assign ld_ready   = !fifo_full;
  assign fifo_push  = ld_valid && !fifo_full;
  // The ALU always owns the write port when it has a result.
  assign fifo_pop   = !alu_valid && !fifo_empty;
  assign fifo_count = fifo_cnt;

  wb_fifo #(
    .WIDTH (ENT_W),
    .TAG_W (ADDR_W),
    .DEPTH (DEPTH)
  ) u_wb_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({ld_addr, ld_data}),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt),
    .tags_o  (fifo_tags),
    .valid_o (fifo_valid)
  );

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_valid) begin
      wr_en_d   = 1'b1;
      wr_addr_d = alu_addr;
      wr_data_d = alu_data;
    end else if (!fifo_empty) begin
      wr_en_d   = 1'b1;
      wr_addr_d = fifo_head[ENT_W-1 -: ADDR_W];
      wr_data_d = fifo_head[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign regWrite  = wr_en_q;
  assign writeAddr = wr_addr_q;
  assign writeData = wr_data_q;

  // --------------------------------------------------------------------------
  // Starvation counter and stall request. The stall register tracks the
  // counter's next value, so it rises together with the counter reaching the
  // limit and falls on the same edge that pops the head.
  // --------------------------------------------------------------------------
  logic [STV_W-1:0] starve_q, starve_d;
  logic             stall_q,  stall_d;

  always_comb begin
    starve_d = '0;
    if (!fifo_empty && !fifo_pop) begin
      if (starve_q == STV_W'(STARVE_LIMIT)) starve_d = starve_q;
      else                                  starve_d = starve_q + STV_W'(1);
    end
    stall_d = (starve_d == STV_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign alu_stall = stall_q;

  // --------------------------------------------------------------------------
  // Busy mask: queued load destinations plus the register on the output stage
  // --------------------------------------------------------------------------
  logic [NREG-1:0] entry_dec [DEPTH];
  logic [NREG-1:0] out_dec;
  logic [NREG-1:0] fifo_busy;

  generate
    if (ADDR_W == REG_ADDR_W) begin : g_pkg_dec
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign entry_dec[gi] = addr_onehot(fifo_tags[gi*ADDR_W +: ADDR_W]);
      end
      assign out_dec = addr_onehot(wr_addr_q);
    end else begin : g_shift_dec
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign entry_dec[gi] = NREG'(1) << fifo_tags[gi*ADDR_W +: ADDR_W];
      end
      assign out_dec = NREG'(1) << wr_addr_q;
    end
  endgenerate

  always_comb begin
    fifo_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid[i]) fifo_busy = fifo_busy | entry_dec[i];
    end
  end

  assign busy_mask = fifo_busy | (wr_en_q ? out_dec : '0);

  // --------------------------------------------------------------------------
  // Hazard flag: an ALU result aimed at a register that still has a queued
  // load overtakes that load. The writes still go out in priority order; the
  // flag only records that the issue stage broke the rule.
  // --------------------------------------------------------------------------
  logic hazard_q, hazard_d;

  assign hazard_d = hazard_q | (alu_valid && fifo_busy[alu_addr]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hazard_q <= 1'b0;
    else     hazard_q <= hazard_d;
  end

  assign wb_hazard = hazard_q;

endmodule : rf_writeback_ctrl
`default_nettype wire
